// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default geometry and FSM encoding.
package reg_dump_reader_pkg;

   localparam int unsigned DEF_ADDR = 5;
   localparam int unsigned DEF_SIZE = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Sweeps a register-file read port over [First_Addr..Last_Addr] (with wrap) and
// streams each word out over a valid/ready handshake.
module reg_dump_reader
   import reg_dump_reader_pkg::*;
#(
   parameter int unsigned ADDR = DEF_ADDR,
   parameter int unsigned SIZE = DEF_SIZE
) (
   input  logic            Clk,
   input  logic            Clr,
   input  logic            Start,
   input  logic            Abort,
   input  logic [ADDR-1:0] First_Addr,
   input  logic [ADDR-1:0] Last_Addr,
   output logic [ADDR-1:0] R_Addr,
   input  logic [SIZE-1:0] R_Data,
   output logic            Out_Valid,
   input  logic            Out_Ready,
   output logic [ADDR-1:0] Out_Addr,
   output logic [SIZE-1:0] Out_Data,
   output logic            Busy,
   output logic            Done,
   output logic [ADDR:0]   Words_Sent
);

   state_t          state_q, state_n;
   logic [ADDR-1:0] last_q, last_n;
   logic            abort_q, abort_n;
   logic [ADDR-1:0] r_addr_n;
   logic            out_valid_n;
   logic [ADDR-1:0] out_addr_n;
   logic [SIZE-1:0] out_data_n;
   logic            busy_n;
   logic            done_n;
   logic [ADDR:0]   words_n;

   // Next-state and next-output logic; every register holds unless a state says otherwise.
   always_comb begin
      state_n     = state_q;
      last_n      = last_q;
      abort_n     = abort_q;
      r_addr_n    = R_Addr;
      out_valid_n = Out_Valid;
      out_addr_n  = Out_Addr;
      out_data_n  = Out_Data;
      words_n     = Words_Sent;

      case (state_q)
         IDLE: begin
            r_addr_n = '0;
            if (Start) begin
               last_n   = Last_Addr;
               r_addr_n = First_Addr;
               words_n  = '0;
               abort_n  = 1'b0;
               state_n  = READ;
            end
         end
         READ: begin
            if (Abort) begin
               state_n = DONE;
            end else begin
               out_data_n  = R_Data;
               out_addr_n  = R_Addr;
               out_valid_n = 1'b1;
               state_n     = SEND;
            end
         end
         SEND: begin
            // Abort is only remembered here; the presented word always completes.
            if (Abort) abort_n = 1'b1;
            if (Out_Valid && Out_Ready) begin
               out_valid_n = 1'b0;
               words_n     = Words_Sent + (ADDR+1)'(1);
               if ((R_Addr == last_q) || abort_q || Abort) begin
                  state_n = DONE;
               end else begin
                  r_addr_n = R_Addr + ADDR'(1);
                  state_n  = READ;
               end
            end
         end
         DONE: begin
            r_addr_n = '0;
            abort_n  = 1'b0;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
      done_n = (state_n == DONE);
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_q    <= IDLE;
         last_q     <= '0;
         abort_q    <= 1'b0;
         R_Addr     <= '0;
         Out_Valid  <= 1'b0;
         Out_Addr   <= '0;
         Out_Data   <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Words_Sent <= '0;
      end else begin
         state_q    <= state_n;
         last_q     <= last_n;
         abort_q    <= abort_n;
         R_Addr     <= r_addr_n;
         Out_Valid  <= out_valid_n;
         Out_Addr   <= out_addr_n;
         Out_Data   <= out_data_n;
         Busy       <= busy_n;
         Done       <= done_n;
         Words_Sent <= words_n;
      end
   end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Debug read-out engine that sits on a spare read port of the CPU register file, on the port's driving side. It sweeps a programmable address range, issuing one address per word on that port. Each returned word is captured into an output register and streamed out over a valid/ready handshake to the debug/display path. It lets the board dump architectural register state without stalling the datapath.

Parameters:
ADDR, 5, register address width; the file has 1<<ADDR registers.
SIZE, 32, register data width.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Clr  input  1  reset, asynchronous, active-high; clears all state.
Start  input  1  begin a sweep; sampled only in IDLE.
Abort  input  1  terminate the sweep early.
First_Addr  input  ADDR  first register address of the sweep.
Last_Addr  input  ADDR  last register address of the sweep, inclusive.
R_Addr  output  ADDR  read address driven to the register file read port.
R_Data  input  SIZE  combinational read data returned for R_Addr.
Out_Valid  output  1  Out_Addr/Out_Data hold a word.
Out_Ready  input  1  sink accepts the word.
Out_Addr  output  ADDR  address of the presented word.
Out_Data  output  SIZE  presented register value.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse when a sweep ends, normally or by Abort.
Words_Sent  output  ADDR+1  count of handshakes completed in the current or last sweep.

Behaviour:
- Reset (Clr=1, asynchronous):
  - state=IDLE.
  - R_Addr, Out_Addr, Out_Data, Words_Sent = 0.
  - Out_Valid, Busy, Done = 0.
  - An in-flight sweep is dropped; no Done pulse is produced.
- IDLE:
  - R_Addr holds 0.
  - On Start=1: latch Last_Addr, set R_Addr=First_Addr, clear Words_Sent, go to READ.
- READ (one cycle):
  - R_Addr is stable for the whole cycle.
  - At the closing edge: Out_Data<=R_Data, Out_Addr<=R_Addr, Out_Valid<=1, go to SEND.
  - If Abort=1 during READ: no capture; go to DONE.
- SEND:
  - Out_Valid=1; Out_Addr and Out_Data are held stable until Out_Valid&Out_Ready.
  - On handshake: Out_Valid<=0 and Words_Sent<=Words_Sent+1.
    - If R_Addr==latched Last_Addr, or Abort is pending: go to DONE.
    - Otherwise: R_Addr<=R_Addr+1 (mod 1<<ADDR) and go to READ.
  - Abort asserted in SEND is remembered (pending flag). It never drops Out_Valid before the handshake completes.
- DONE (one cycle):
  - Done=1, Busy=1.
  - Next state IDLE; R_Addr returns to 0.
  - Words_Sent holds until the next Start.
- Latency and throughput:
  - Start at edge n gives READ in cycle n+1 and Out_Valid=1 from cycle n+2.
  - One word per 2 cycles with Out_Ready tied high.
- Range and wrap-around:
  - First==Last: exactly one word.
  - First>Last: the address wraps through (1<<ADDR)-1 to 0, e.g. 30,31,0,1.
  - First=0, Last=(1<<ADDR)-1: all 32 words, Words_Sent=32. The counter is ADDR+1 bits wide so this value fits.
- Start while Busy: ignored. First_Addr and Last_Addr changes while Busy: ignored (Last is latched).
- Read-during-write: if the CPU writes register k in the same cycle the block is in READ with R_Addr=k, the old value is captured. This follows from the combinational read port.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3.
  - Defaults ADDR=5 and SIZE=32, shared with the register file.
- No sub-module; a single FSM plus address counter and output register.
- The testbench instantiates the existing register file as the R_Addr/R_Data responder.

Test Plan:
- Full sweep: preload reg[i]=0x1000+i, First=0, Last=31, Out_Ready=1.
  -> 32 words, addr 0..31, data 0x1000..0x101F, in order.
  -> Done pulse 1 cycle after the last handshake; Words_Sent=32.
- Backpressure: First=4, Last=6, Out_Ready low for 5 cycles on each word.
  -> Out_Data stays constant while waiting; words 0x1004, 0x1005, 0x1006; no drops or duplicates.
- Wrap and single-word sweeps:
  -> First=30, Last=1 gives addrs 30,31,0,1 with Words_Sent=4.
  -> First=Last=7 gives exactly one word, 0x1007.
- Abort: assert Abort during SEND of addr 2 in a 0..31 sweep.
  -> The addr-2 word completes its handshake, then Done; Words_Sent=3; no further Out_Valid.
- Reset mid-sweep: assert Clr asynchronously mid-cycle during SEND.
  -> Out_Valid, Busy and R_Addr go to 0 immediately; no Done pulse.
  -> A subsequent Start runs a clean sweep.
- Start ignored while busy: pulse Start during a sweep with different First/Last.
  -> The sweep continues with the original range, and exactly one Done pulse is produced.
